// File: rtl/iomem_timer_if.sv
// iomem_timer_if: PicoSoC iomem bus bundle between the CPU side and a peripheral
interface iomem_timer_if;
   logic        valid;
   logic        ready;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   modport master (output valid, wstrb, addr, wdata, input ready, rdata);
   modport slave (input valid, wstrb, addr, wdata, output ready, rdata);
endinterface

// File: rtl/iomem_timer.sv
// iomem_timer: memory-mapped prescaled down-counting timer with level irq on the iomem bus
module iomem_timer #(
   parameter logic [7:0] ADDR_HI = 8'h04,
   parameter int PRESCALE_W = 16
) (
   input  logic clk,
   input  logic reset,
   iomem_timer_if.slave bus,
   output logic irq
);
   logic en, auto_reload, irq_en, expired;
   logic [PRESCALE_W-1:0] prescale, pcnt, prescale_n, pcnt_n;
   logic [31:0] count, reload, count_n, reload_n, mask, pre_ext, rd_val;
   logic hit, wr, tick, zero, expire, en_n, clr_pcnt;
   logic ctrl_wr, pre_wr, cnt_wr, rld_wr, st_clr;
   logic [2:0] sel;
   logic unused_bits;
   assign hit = bus.valid & ~bus.ready & (bus.addr[31:24] == ADDR_HI);
   assign sel = bus.addr[4:2];
   assign wr = hit & (|bus.wstrb);
   assign mask = {{8{bus.wstrb[3]}}, {8{bus.wstrb[2]}}, {8{bus.wstrb[1]}}, {8{bus.wstrb[0]}}};
   assign pre_ext = 32'(prescale);
   assign tick = en & (pcnt == prescale);
   assign zero = count == 32'd0;
   assign expire = tick & zero;
   assign ctrl_wr = wr & (sel == 3'd0) & bus.wstrb[0];
   assign pre_wr = wr & (sel == 3'd1);
   assign cnt_wr = wr & (sel == 3'd2);
   assign rld_wr = wr & (sel == 3'd3);
   assign st_clr = wr & (sel == 3'd4) & bus.wstrb[0] & bus.wdata[0];
   assign en_n = ctrl_wr ? bus.wdata[0] : en & ~(expire & ~auto_reload);
   assign clr_pcnt = pre_wr | (ctrl_wr & bus.wdata[0] & ~en);
   assign pcnt_n = (tick | clr_pcnt | ~en_n) ? '0 : pcnt + PRESCALE_W'(1);
   assign prescale_n = pre_wr ? PRESCALE_W'((pre_ext & ~mask) | (bus.wdata & mask)) : prescale;
   assign reload_n = rld_wr ? (reload & ~mask) | (bus.wdata & mask) : reload;
   assign count_n = cnt_wr ? (count & ~mask) | (bus.wdata & mask) :
                    ~tick ? count : ~zero ? count - 32'd1 : auto_reload ? reload : count;
   assign unused_bits = ^{bus.addr[23:5], bus.addr[1:0]};
   // register read mux, sampled before this cycle's tick or write lands
   always_comb begin
      rd_val = '0;
      case (sel)
         3'd0: rd_val = {29'd0, irq_en, auto_reload, en};
         3'd1: rd_val = pre_ext;
         3'd2: rd_val = count;
         3'd3: rd_val = reload;
         3'd4: rd_val = {31'd0, expired};
         default: rd_val = '0;
      endcase
   end
   // timer state, bus acknowledge and registered interrupt
   always_ff @(posedge clk) begin
      if (reset) begin
         en <= 1'b0;
         auto_reload <= 1'b0;
         irq_en <= 1'b0;
         expired <= 1'b0;
         prescale <= '0;
         pcnt <= '0;
         count <= '0;
         reload <= '0;
         bus.ready <= 1'b0;
         bus.rdata <= '0;
         irq <= 1'b0;
      end else begin
         en <= en_n;
         auto_reload <= ctrl_wr ? bus.wdata[1] : auto_reload;
         irq_en <= ctrl_wr ? bus.wdata[2] : irq_en;
         expired <= expire | (expired & ~st_clr);
         prescale <= prescale_n;
         pcnt <= pcnt_n;
         count <= count_n;
         reload <= reload_n;
         bus.ready <= hit;
         bus.rdata <= hit ? rd_val : bus.rdata;
         irq <= expired & irq_en;
      end
   end
endmodule

// File: tb/tb_iomem_timer.sv
// tb_iomem_timer: directed bench with a per-cycle behavioural model of the timer
module tb_iomem_timer;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic irq;
   int checks = 0;
   int errors = 0;
   iomem_timer_if bus();
   iomem_timer dut (.clk(clk), .reset(reset), .bus(bus), .irq(irq));
   always #5 clk = ~clk;

   logic m_ok = 1'b0, m_en = 1'b0, m_ar = 1'b0, m_ie = 1'b0, m_exp = 1'b0, m_ready = 1'b0, m_irq = 1'b0;
   logic [15:0] m_pre = '0, m_pcnt = '0;
   logic [31:0] m_count = '0, m_reload = '0, m_rdata = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // behavioural model: apply the timer rules, then let a bus write override them
   always @(posedge clk) begin
      logic hit, wr_en, tick, set, old_en;
      logic [2:0] off;
      logic [31:0] rd, p32;
      if (reset) begin
         m_en = 0; m_ar = 0; m_ie = 0; m_exp = 0; m_ready = 0; m_irq = 0;
         m_pre = 0; m_pcnt = 0; m_count = 0; m_reload = 0; m_rdata = 0;
         m_ok = 1;
      end else begin
         off = bus.addr[4:2];
         hit = bus.valid && !m_ready && bus.addr[31:24] == 8'h04;
         wr_en = hit && bus.wstrb != 4'd0;
         case (off)
            3'd0: rd = {29'd0, m_ie, m_ar, m_en};
            3'd1: rd = {16'd0, m_pre};
            3'd2: rd = m_count;
            3'd3: rd = m_reload;
            3'd4: rd = {31'd0, m_exp};
            default: rd = 0;
         endcase
         m_irq = m_exp && m_ie;
         old_en = m_en;
         tick = m_en && m_pcnt == m_pre;
         set = tick && m_count == 0;
         if (tick) begin
            m_pcnt = 0;
            if (m_count != 0) m_count = m_count - 1;
            else begin
               m_exp = 1;
               if (m_ar) m_count = m_reload;
               else m_en = 0;
            end
         end else if (m_en) m_pcnt = m_pcnt + 1;
         if (wr_en) begin
            case (off)
               3'd0: if (bus.wstrb[0]) begin
                  if (!old_en && bus.wdata[0]) m_pcnt = 0;
                  m_en = bus.wdata[0]; m_ar = bus.wdata[1]; m_ie = bus.wdata[2];
               end
               3'd1: begin
                  p32 = {16'd0, m_pre};
                  for (int i = 0; i < 4; i++) if (bus.wstrb[i]) p32[i*8 +: 8] = bus.wdata[i*8 +: 8];
                  m_pre = p32[15:0];
                  m_pcnt = 0;
               end
               3'd2: for (int i = 0; i < 4; i++) if (bus.wstrb[i]) m_count[i*8 +: 8] = bus.wdata[i*8 +: 8];
               3'd3: for (int i = 0; i < 4; i++) if (bus.wstrb[i]) m_reload[i*8 +: 8] = bus.wdata[i*8 +: 8];
               3'd4: if (bus.wstrb[0] && bus.wdata[0] && !set) m_exp = 0;
               default: ;
            endcase
         end
         if (!m_en) m_pcnt = 0;
         m_ready = hit;
         if (hit) m_rdata = rd;
      end
   end

   // compare DUT outputs to the model every cycle, away from the clock edge
   always @(negedge clk) begin
      if (m_ok) begin
         chk("model_ready", 32'(bus.ready), 32'(m_ready));
         chk("model_irq", 32'(irq), 32'(m_irq));
         if (m_ready) chk("model_rdata", bus.rdata, m_rdata);
      end
   end

   task automatic xfer(input logic [2:0] off, input logic [3:0] s, input logic [31:0] d,
                       output logic [31:0] r, output int lat);
      @(posedge clk); #1;
      bus.valid = 1; bus.addr = 32'h0400_0000 | {27'd0, off, 2'b00}; bus.wstrb = s; bus.wdata = d;
      lat = 0;
      do begin @(posedge clk); #1; lat++; end while (!bus.ready && lat < 4);
      bus.valid = 0; bus.wstrb = 0;
      chk("ack_seen", 32'(bus.ready), 32'd1);
      r = bus.rdata;
   endtask

   task automatic wr(input logic [2:0] off, input logic [3:0] s, input logic [31:0] d);
      logic [31:0] r;
      int l;
      xfer(off, s, d, r, l);
   endtask

   task automatic rd_chk(input string name, input logic [2:0] off, input logic [31:0] exp);
      logic [31:0] r;
      int l;
      xfer(off, 4'd0, 32'd0, r, l);
      chk(name, r, exp);
   endtask

   task automatic wait_irq(input int budget, output int n);
      n = 0;
      while (!irq && n < budget) begin @(posedge clk); #1; n++; end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] r;
      int l, n;
      bus.valid = 0; bus.wstrb = 0; bus.addr = 0; bus.wdata = 0;
      repeat (3) @(posedge clk);
      #1 reset = 0;
      for (int i = 0; i < 8; i++) begin
         xfer(3'(i), 4'd0, 32'd0, r, l);
         chk("reset_read", r, 32'd0);
         chk("ack_latency", 32'(l), 32'd1);
      end
      chk("reset_irq", 32'(irq), 32'd0);
      wr(3'd1, 4'hF, 32'd3);
      wr(3'd2, 4'hF, 32'd4);
      wr(3'd0, 4'hF, 32'd5);
      wait_irq(40, n);
      chk("oneshot_irq_cycles", 32'(n), 32'd21);
      rd_chk("oneshot_ctrl", 3'd0, 32'd4);
      rd_chk("oneshot_count", 3'd2, 32'd0);
      rd_chk("oneshot_status", 3'd4, 32'd1);
      wr(3'd4, 4'h1, 32'd1);
      @(posedge clk); #1;
      chk("oneshot_irq_clear", 32'(irq), 32'd0);
      wr(3'd1, 4'hF, 32'd0);
      wr(3'd3, 4'hF, 32'd9);
      wr(3'd2, 4'hF, 32'd9);
      wr(3'd0, 4'hF, 32'd7);
      wait_irq(20, n);
      chk("reload_irq_cycles", 32'(n), 32'd11);
      for (int i = 0; i < 4; i++) rd_chk("reload_count", 3'd2, 32'(7 - 2 * i));
      wr(3'd4, 4'h1, 32'd1);
      @(posedge clk); #1;
      chk("w1c_irq_drop", 32'(irq), 32'd0);
      wait_irq(20, n);
      chk("irq_reassert", 32'(irq), 32'd1);
      wr(3'd2, 4'hF, 32'd100);
      rd_chk("count_write_vs_tick", 3'd2, 32'd99);
      wr(3'd3, 4'hF, 32'd0);
      wr(3'd2, 4'hF, 32'd0);
      wr(3'd4, 4'h1, 32'd1);
      rd_chk("w1c_vs_expiry", 3'd4, 32'd1);
      wr(3'd0, 4'hF, 32'd0);
      wr(3'd4, 4'h1, 32'd1);
      rd_chk("status_cleared", 3'd4, 32'd0);
      wr(3'd3, 4'hF, 32'd0);
      wr(3'd3, 4'b0101, 32'hAABB_CCDD);
      rd_chk("reload_bytes", 3'd3, 32'h00BB_00DD);
      wr(3'd1, 4'b0010, 32'h0000_1234);
      rd_chk("prescale_byte", 3'd1, 32'h0000_1200);
      wr(3'd1, 4'hF, 32'hFFFF_FFFF);
      rd_chk("prescale_width", 3'd1, 32'h0000_FFFF);
      wr(3'd6, 4'hF, 32'hFFFF_FFFF);
      rd_chk("offset6", 3'd6, 32'd0);
      @(posedge clk); #1;
      bus.valid = 1; bus.addr = 32'h0300_0008; bus.wstrb = 0;
      repeat (4) begin
         @(posedge clk); #1;
         chk("miss_ready", 32'(bus.ready), 32'd0);
      end
      bus.valid = 0;
      wr(3'd1, 4'hF, 32'd3);
      wr(3'd2, 4'hF, 32'd5);
      wr(3'd0, 4'hF, 32'd5);
      @(posedge clk); #1;
      bus.valid = 1; bus.addr = 32'h0400_0008; bus.wstrb = 0;
      @(posedge clk); #1;
      reset = 1; bus.valid = 0;
      @(posedge clk); #1;
      chk("reset_kills_ready", 32'(bus.ready), 32'd0);
      reset = 0;
      for (int i = 0; i < 8; i++) begin
         xfer(3'(i), 4'd0, 32'd0, r, l);
         chk("midop_reset_read", r, 32'd0);
      end
      chk("midop_reset_irq", 32'(irq), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/iomem_timer.md
# iomem_timer

Memory-mapped down-counting timer on the PicoSoC `iomem` bus, alongside the GPIO peripheral at `0x03xx_xxxx`. It decodes its own address window, answers CPU loads and stores with the same one-cycle ready handshake, and drives a level interrupt into the SoC's `irq_5` input. The top level ORs its `iomem_ready` with the other peripherals' ready signals and muxes `iomem_rdata` by `iomem_addr[31:24]`.

## Interface
- `ADDR_HI`, default `8'h04`: value of `iomem_addr[31:24]` that selects this block.
- `PRESCALE_W`, default `16`: width of the prescaler register and counter (1..32).
- `clk` in 1: system clock (`clk_bufg` domain).
- `reset` in 1: one clock; reset is synchronous and active-high.
- `iomem_valid` in 1: bus request valid.
- `iomem_ready` out 1: one-cycle acknowledge.
- `iomem_wstrb` in 4: byte write strobes; `0000` means read.
- `iomem_addr` in 32: byte address; bits `[4:2]` select the register.
- `iomem_wdata` in 32: write data.
- `iomem_rdata` out 32: read data, valid while `iomem_ready`=1.
- `irq` out 1: level interrupt, `STATUS.expired & CTRL.irq_en`.

## Operation
- **Register map** (offset = `addr[4:2]`):
  - `0` CTRL: bit0 `en`, bit1 `auto_reload`, bit2 `irq_en`.
  - `1` PRESCALE: `[PRESCALE_W-1:0]`.
  - `2` COUNT: 32 bits.
  - `3` RELOAD: 32 bits.
  - `4` STATUS: bit0 `expired`; write-1-to-clear.
  - `5`–`7`: read 0; writes ignored.
  - Unused bits read 0.
- **Byte strobes.** Every writable register honours each `wstrb[i]` independently. For STATUS, clearing is done by `wstrb[0]` together with `wdata[0]`=1.
- **Decode.** `hit = iomem_valid & !iomem_ready & (iomem_addr[31:24] == ADDR_HI)`.
  - If `hit`: next cycle `iomem_ready`=1, `iomem_rdata` = selected register, and the write is applied.
  - If not `hit`: `iomem_ready`=0 and `iomem_rdata` holds its value.
- **Prescaler.** When `en`=1, `pcnt` counts from 0 to PRESCALE. At `pcnt == PRESCALE` a `tick` fires and `pcnt` returns to 0. When `en`=0, `pcnt` is held at 0.
- **On `tick`:**
  - If `COUNT != 0`: `COUNT <= COUNT - 1`.
  - If `COUNT == 0`: `expired <= 1`. Then, if `auto_reload`, `COUNT <= RELOAD`; otherwise `en <= 0`.
  - Resulting expiry period: (COUNT+1)·(PRESCALE+1) cycles; the auto-reload period is (RELOAD+1)·(PRESCALE+1).
- **Prescaler clearing.** Any write to PRESCALE, and any CTRL write that takes `en` from 0 to 1, clears `pcnt` to 0.
- **Arithmetic.** All values are unsigned. COUNT decrements only from nonzero values, so it never wraps.

## Timing
- **Reset values.** All registers, `pcnt`, `iomem_ready`, `iomem_rdata` and `irq` are 0.
  - `reset` asserted mid-operation clears everything on the next edge, including a pending `iomem_ready`.
- **Bus latency.** Exactly one cycle from a `hit` to `iomem_ready`=1. `iomem_ready` lasts one cycle. Back-to-back requests are acknowledged every second cycle.
- **Read/update ordering.** A read returns the register value from before that cycle's tick or write takes effect.
- **Bus write vs. tick, same cycle:**
  - A bus write to COUNT wins over the tick's decrement or reload.
  - A CTRL write wins over the auto-disable of `en`.
- **W1C vs. expiry, same cycle.** When a STATUS W1C coincides with a new expiry, the set wins and `expired` stays 1.
- **`irq` timing.** `irq` is registered and rises the cycle after `expired` and `irq_en` are both 1. It falls the cycle after the clearing write is acknowledged.
- **PRESCALE = 0.** A tick fires every cycle while `en`=1.

## Test plan
- **Reset values:** hold `reset` for 3 cycles, then read all 8 offsets → every read returns 0; `irq`=0; each `iomem_ready` pulse is exactly 1 cycle long, 1 cycle after `valid`.
- **One-shot expiry:** PRESCALE=3, COUNT=4, CTRL=`0b101` → `expired` sets 20 cycles after the enabling write's ack; `irq` rises 1 cycle later; CTRL reads `0b100`; COUNT=0.
- **Auto-reload:** PRESCALE=0, RELOAD=9, COUNT=9, CTRL=`0b111` → `expired` sets every 10 cycles; COUNT reads sequence 9…0,9; writing STATUS=1 drops `irq` and it re-asserts on the next expiry.
- **Byte strobes:** write `0xAABBCCDD` to RELOAD with `wstrb=0b0101` after RELOAD=0 → RELOAD reads `0x00BB00DD`; offset 6 reads 0 and ignores writes.
- **Collisions:**
  - Force a COUNT write to coincide with a tick → the written value is kept with no decrement.
  - Force a STATUS W1C to coincide with an expiry → `expired` remains 1.
- **Address miss and mid-op reset:**
  - `iomem_addr=0x0300_0008` → `iomem_ready` stays 0.
  - Assert `reset` while the timer is running at COUNT=5 → all registers read 0 and `irq`=0.
